// File: rtl/sram_engine_pkg.sv
// Shared definitions for the SRAM bulk engine: host register map, cycle FSM
// state encoding, status bit positions and the cycle-type enum.
package sram_engine_pkg;

  // Host register addresses
  localparam logic [7:0] REG_DATA   = 8'h10;
  localparam logic [7:0] REG_CTRL   = 8'h11;
  localparam logic [7:0] REG_ADDR0  = 8'h12;
  localparam logic [7:0] REG_ADDR1  = 8'h13;
  localparam logic [7:0] REG_ADDR2  = 8'h14;
  localparam logic [7:0] REG_WAIT   = 8'h15;
  localparam logic [7:0] REG_STATUS = 8'h16;
  localparam logic [7:0] REG_ID_LO  = 8'hFD;
  localparam logic [7:0] REG_ID_HI  = 8'hFE;
  localparam logic [7:0] REG_REV    = 8'hFF;

  // Control register bit positions (START is a command, never stored)
  localparam int CTRL_START    = 0;
  localparam int CTRL_AUTOINC  = 1;
  localparam int CTRL_PREFETCH = 2;

  // Status register bit positions
  localparam int STAT_BUSY   = 0;
  localparam int STAT_RVALID = 1;
  localparam int STAT_OVR    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } cyc_state_t;

  typedef enum logic {
    CYC_READ  = 1'b0,
    CYC_WRITE = 1'b1
  } cyc_kind_t;

  // Assemble the status byte from its flag bits
  function automatic logic [7:0] status_byte(input logic ovr, input logic rvalid,
                                             input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVR]    = ovr;
    s[STAT_RVALID] = rvalid;
    s[STAT_BUSY]   = busy;
    return s;
  endfunction

endpackage

// File: rtl/sram_cycle_fsm.sv
// Timing engine for one asynchronous SRAM access: SETUP, PULSE (wait+1
// clocks), HOLD. Strobes are decoded from the state register so an
// asynchronous reset releases them immediately.
module sram_cycle_fsm
  import sram_engine_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  cyc_kind_t         start_kind,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic              busy,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              dq_oe,
  output logic              capture,
  output logic              done
);

  cyc_state_t        state_reg, state_next;
  cyc_kind_t         kind_reg, kind_next;
  logic [WAIT_W-1:0] cnt_reg, cnt_next;

  // State, cycle type and pulse-width counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      kind_reg  <= CYC_READ;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      kind_reg  <= kind_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and strobe decode; capture fires on the PULSE->HOLD edge
  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    ce_n       = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    dq_oe      = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
          kind_next  = start_kind;
          cnt_next   = wait_cycles;
        end
      end
      ST_SETUP: begin
        busy       = 1'b1;
        ce_n       = 1'b0;
        dq_oe      = (kind_reg == CYC_WRITE);
        state_next = ST_PULSE;
      end
      ST_PULSE: begin
        busy  = 1'b1;
        ce_n  = 1'b0;
        oe_n  = (kind_reg != CYC_READ);
        we_n  = (kind_reg != CYC_WRITE);
        dq_oe = (kind_reg == CYC_WRITE);
        if (cnt_reg == '0) begin
          state_next = ST_HOLD;
          capture    = (kind_reg == CYC_READ);
        end else begin
          cnt_next = cnt_reg - WAIT_W'(1);
        end
      end
      ST_HOLD: begin
        busy       = 1'b1;
        ce_n       = 1'b0;
        dq_oe      = (kind_reg == CYC_WRITE);
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_bulk_engine.sv
// Host register file for bulk SRAM access: decodes byte-wide host accesses,
// holds address/data/control state and launches cycles on sram_cycle_fsm.
module sram_bulk_engine
  import sram_engine_pkg::*;
#(
  parameter int          ADDR_W      = 15,
  parameter int          DATA_W      = 8,
  parameter int          WAIT_W      = 4,
  parameter logic [15:0] RUNTIME_ID  = 16'h000B,
  parameter logic [7:0]  RUNTIME_REV = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        reg_addr,
  input  logic [7:0]        reg_wdata,
  input  logic              reg_wr,
  input  logic              reg_rd,
  output logic [7:0]        reg_rdata,
  output logic [ADDR_W-1:0] dut_addr,
  output logic [DATA_W-1:0] dut_dq_out,
  output logic              dut_dq_oe,
  input  logic [DATA_W-1:0] dut_dq_in,
  output logic              dut_ce_n,
  output logic              dut_oe_n,
  output logic              dut_we_n,
  output logic              busy
);

  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] dq_out_reg, dq_out_next;
  logic [DATA_W-1:0] rbuf_reg, rbuf_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [7:0]        rdata_reg, rdata_next;
  logic              rvalid_reg, rvalid_next;
  logic              ovr_reg, ovr_next;
  logic              auto_inc_reg, auto_inc_next;
  logic              prefetch_reg, prefetch_next;

  logic [23:0]       addr_wide;
  logic              start;
  cyc_kind_t         start_kind;
  logic              ovr_set, ovr_clr, rvalid_clr;
  logic              fsm_busy, capture, done;

  sram_cycle_fsm #(.WAIT_W(WAIT_W)) u_cycle_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_kind (start_kind),
    .wait_cycles(wait_reg),
    .busy       (fsm_busy),
    .ce_n       (dut_ce_n),
    .oe_n       (dut_oe_n),
    .we_n       (dut_we_n),
    .dq_oe      (dut_dq_oe),
    .capture    (capture),
    .done       (done)
  );

  // Host decode: writes act first, reads return the state before this edge
  always_comb begin
    addr_next     = addr_reg;
    dq_out_next   = dq_out_reg;
    wait_next     = wait_reg;
    rdata_next    = rdata_reg;
    auto_inc_next = auto_inc_reg;
    prefetch_next = prefetch_reg;
    addr_wide     = 24'(addr_reg);
    start         = 1'b0;
    start_kind    = CYC_READ;
    ovr_set       = 1'b0;
    ovr_clr       = 1'b0;
    rvalid_clr    = 1'b0;

    if (reg_wr) begin
      case (reg_addr)
        REG_DATA: begin
          if (fsm_busy) ovr_set = 1'b1;
          else begin
            dq_out_next = reg_wdata[DATA_W-1:0];
            start       = 1'b1;
            start_kind  = CYC_WRITE;
          end
        end
        REG_CTRL: begin
          auto_inc_next = reg_wdata[CTRL_AUTOINC];
          prefetch_next = reg_wdata[CTRL_PREFETCH];
          if (reg_wdata[CTRL_START]) begin
            if (fsm_busy) ovr_set = 1'b1;
            else start = 1'b1;
          end
        end
        REG_ADDR0, REG_ADDR1, REG_ADDR2: begin
          if (fsm_busy) ovr_set = 1'b1;
          else begin
            if (reg_addr == REG_ADDR0) addr_wide[7:0]   = reg_wdata;
            if (reg_addr == REG_ADDR1) addr_wide[15:8]  = reg_wdata;
            if (reg_addr == REG_ADDR2) addr_wide[23:16] = reg_wdata;
            addr_next = addr_wide[ADDR_W-1:0];
          end
        end
        REG_WAIT: begin
          if (fsm_busy) ovr_set = 1'b1;
          else wait_next = WAIT_W'(reg_wdata);
        end
        default: ;
      endcase
    end

    if (reg_rd) begin
      case (reg_addr)
        REG_DATA: begin
          rdata_next = 8'(rbuf_reg);
          rvalid_clr = 1'b1;
          // A prefetch cannot start while busy or when a write cycle
          // was launched by the simultaneous host write.
          if (fsm_busy || (prefetch_reg && start)) ovr_set = 1'b1;
          else if (prefetch_reg) begin
            start      = 1'b1;
            start_kind = CYC_READ;
          end
        end
        REG_STATUS: begin
          rdata_next = status_byte(ovr_reg, rvalid_reg, fsm_busy);
          ovr_clr    = 1'b1;
        end
        REG_ID_LO: rdata_next = RUNTIME_ID[7:0];
        REG_ID_HI: rdata_next = RUNTIME_ID[15:8];
        REG_REV:   rdata_next = RUNTIME_REV;
        default:   rdata_next = 8'h00;
      endcase
    end

    // Address advances as the cycle leaves HOLD; host address writes are
    // rejected while busy, so the two never coincide.
    if (done && auto_inc_reg) addr_next = addr_reg + ADDR_W'(1);

    rbuf_next   = capture ? dut_dq_in : rbuf_reg;
    rvalid_next = capture ? 1'b1 : (rvalid_clr ? 1'b0 : rvalid_reg);
    ovr_next    = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_reg);
  end

  // Register file state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      dq_out_reg   <= '0;
      rbuf_reg     <= '0;
      wait_reg     <= '0;
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
      ovr_reg      <= 1'b0;
      auto_inc_reg <= 1'b0;
      prefetch_reg <= 1'b0;
    end else begin
      addr_reg     <= addr_next;
      dq_out_reg   <= dq_out_next;
      rbuf_reg     <= rbuf_next;
      wait_reg     <= wait_next;
      rdata_reg    <= rdata_next;
      rvalid_reg   <= rvalid_next;
      ovr_reg      <= ovr_next;
      auto_inc_reg <= auto_inc_next;
      prefetch_reg <= prefetch_next;
    end
  end

  assign dut_addr   = addr_reg;
  assign dut_dq_out = dq_out_reg;
  assign reg_rdata  = rdata_reg;
  assign busy       = fsm_busy;

endmodule

// File: tb/tb_sram_bulk_engine.sv
// Self-checking bench for sram_bulk_engine with a behavioural SRAM attached.
module tb_sram_bulk_engine;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        reg_addr = 8'h00;
  logic [7:0]        reg_wdata = 8'h00;
  logic              reg_wr = 1'b0;
  logic              reg_rd = 1'b0;
  logic [7:0]        reg_rdata;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_dq_out;
  logic              dut_dq_oe;
  logic [DATA_W-1:0] dut_dq_in;
  logic              dut_ce_n, dut_oe_n, dut_we_n;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sram [0:DEPTH-1];

  sram_bulk_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W),
    .RUNTIME_ID(16'h000B), .RUNTIME_REV(8'h01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .dut_addr(dut_addr), .dut_dq_out(dut_dq_out), .dut_dq_oe(dut_dq_oe),
    .dut_dq_in(dut_dq_in),
    .dut_ce_n(dut_ce_n), .dut_oe_n(dut_oe_n), .dut_we_n(dut_we_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: reads are combinational, writes land on the /WE rising edge
  assign dut_dq_in = sram[dut_addr];
  always @(posedge dut_we_n) if (dut_ce_n === 1'b0) sram[dut_addr] <= dut_dq_out;

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    $display("[%0t] wr reg %02h <= %02h", $time, a, d);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    reg_addr = a; reg_rd = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0;
    d = reg_rdata;
    $display("[%0t] rd reg %02h -> %02h", $time, a, d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] addrs [5];
    logic [7:0] exps  [5];
    logic [7:0] d;
    addrs = '{8'hFD, 8'hFE, 8'hFF, 8'h16, 8'h20};
    exps  = '{8'h0B, 8'h00, 8'h01, 8'h00, 8'h00};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dut_ce_n, dut_oe_n, dut_we_n, dut_dq_oe, busy} !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b, required 11100",
               {dut_ce_n, dut_oe_n, dut_we_n, dut_dq_oe, busy});
    end
    vectors++;
    if (dut_addr !== '0 || dut_dq_out !== '0 || reg_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_regs: addr=%h dq=%h rdata=%h, required 0", dut_addr, dut_dq_out, reg_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      host_read(addrs[i], d);
      vectors++;
      if (d !== exps[i]) begin
        miscompares++;
        $display("FAIL reset_read_%02h: got %02h, required %02h", addrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_write_cycle();
    int ce_cnt, we_cnt, oe_cnt, busy_cnt, we_first, we_last;
    logic dq_ok;
    ce_cnt = 0; we_cnt = 0; oe_cnt = 0; busy_cnt = 0; we_first = 0; we_last = 0; dq_ok = 1'b1;
    host_write(8'h15, 8'h02);
    host_write(8'h12, 8'h34);
    host_write(8'h13, 8'h12);
    host_write(8'h11, 8'h00);
    host_write(8'h10, 8'hA5);
    for (int i = 1; i <= 8; i++) begin
      if (dut_ce_n === 1'b0) begin
        ce_cnt++;
        if (dut_dq_out !== 8'hA5) dq_ok = 1'b0;
      end
      if (dut_we_n === 1'b0) begin
        we_cnt++;
        if (we_first == 0) we_first = i;
        we_last = i;
      end
      if (dut_dq_oe === 1'b1) oe_cnt++;
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (ce_cnt != 5 || busy_cnt != 5) begin
      miscompares++;
      $display("FAIL write_len: ce_low=%0d busy=%0d, required 5/5", ce_cnt, busy_cnt);
    end
    vectors++;
    if (we_cnt != 3 || we_first != 2 || we_last != 4) begin
      miscompares++;
      $display("FAIL write_we: cnt=%0d first=%0d last=%0d, required 3/2/4", we_cnt, we_first, we_last);
    end
    vectors++;
    if (oe_cnt != 5 || !dq_ok) begin
      miscompares++;
      $display("FAIL write_dq: dq_oe cycles=%0d dq_ok=%b, required 5/1", oe_cnt, dq_ok);
    end
    vectors++;
    if (dut_addr !== 15'h1234 || sram[15'h1234] !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_result: addr=%h mem=%h, required 1234/a5", dut_addr, sram[15'h1234]);
    end
  endtask

  task automatic test_prefetch_wrap();
    logic [7:0] d;
    sram[15'h7FFF] = 8'h3C;
    sram[15'h0000] = 8'h5A;
    host_write(8'h11, 8'h06);
    host_write(8'h12, 8'hFF);
    host_write(8'h13, 8'h7F);
    host_write(8'h11, 8'h07);
    wait_idle();
    vectors++;
    if (dut_addr !== 15'h0000) begin
      miscompares++;
      $display("FAIL prefetch_wrap_addr: got %h, required 0000", dut_addr);
    end
    host_read(8'h10, d);
    vectors++;
    if (d !== 8'h3C) begin
      miscompares++;
      $display("FAIL prefetch_first: got %02h, required 3c", d);
    end
    vectors++;
    if (busy !== 1'b1 || dut_addr !== 15'h0000) begin
      miscompares++;
      $display("FAIL prefetch_start: busy=%b addr=%h, required 1/0000", busy, dut_addr);
    end
    wait_idle();
    host_read(8'h10, d);
    vectors++;
    if (d !== 8'h5A) begin
      miscompares++;
      $display("FAIL prefetch_second: got %02h, required 5a", d);
    end
    wait_idle();
  endtask

  task automatic test_read_wait0();
    int busy_cnt, oe_cnt;
    logic [7:0] d;
    busy_cnt = 0; oe_cnt = 0;
    host_write(8'h15, 8'h00);
    host_write(8'h11, 8'h01);
    for (int i = 1; i <= 6; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (dut_oe_n === 1'b0) oe_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (busy_cnt != 3 || oe_cnt != 1) begin
      miscompares++;
      $display("FAIL read_wait0: busy=%0d oe_low=%0d, required 3/1", busy_cnt, oe_cnt);
    end
    host_read(8'h16, d);
    vectors++;
    if (d !== 8'h02) begin
      miscompares++;
      $display("FAIL read_wait0_status: got %02h, required 02", d);
    end
  endtask

  task automatic test_busy_reject();
    int extra;
    logic [7:0] d;
    extra = 0;
    host_write(8'h15, 8'h05);
    host_write(8'h12, 8'h00);
    host_write(8'h13, 8'h01);
    host_write(8'h10, 8'h22);
    host_write(8'h12, 8'hFF);
    host_write(8'h10, 8'h11);
    vectors++;
    if (dut_addr !== 15'h0100 || dut_dq_out !== 8'h22) begin
      miscompares++;
      $display("FAIL busy_reject_regs: addr=%h dq=%h, required 0100/22", dut_addr, dut_dq_out);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) extra++;
      @(negedge clk);
    end
    vectors++;
    if (extra != 0 || sram[15'h0100] !== 8'h22) begin
      miscompares++;
      $display("FAIL busy_reject_cycle: extra busy=%0d mem=%02h, required 0/22", extra, sram[15'h0100]);
    end
    host_read(8'h16, d);
    vectors++;
    if (d !== 8'h06) begin
      miscompares++;
      $display("FAIL busy_reject_ovr: got %02h, required 06", d);
    end
    host_read(8'h16, d);
    vectors++;
    if (d !== 8'h02) begin
      miscompares++;
      $display("FAIL busy_reject_ovr_clear: got %02h, required 02", d);
    end
  endtask

  task automatic test_burst_random();
    logic [7:0]        bytes [4];
    logic [ADDR_W-1:0] base, exp_addr;
    logic [7:0]        d, w;
    for (int it = 0; it < 6; it++) begin
      base = (it == 0) ? ADDR_W'(DEPTH - 2) : ADDR_W'($urandom_range(0, DEPTH - 1));
      w = 8'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom_range(0, 255));
      host_write(8'h15, w);
      host_write(8'h11, 8'h02);
      host_write(8'h12, base[7:0]);
      host_write(8'h13, 8'(base >> 8));
      host_write(8'h14, 8'h00);
      for (int k = 0; k < 4; k++) begin
        host_write(8'h10, bytes[k]);
        wait_idle();
      end
      exp_addr = ADDR_W'((int'(base) + 4) % DEPTH);
      vectors++;
      if (dut_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL burst_wr_addr it%0d: got %h, required %h", it, dut_addr, exp_addr);
      end
      host_write(8'h12, base[7:0]);
      host_write(8'h13, 8'(base >> 8));
      host_write(8'h11, 8'h07);
      wait_idle();
      for (int k = 0; k < 4; k++) begin
        host_read(8'h10, d);
        vectors++;
        if (d !== bytes[k]) begin
          miscompares++;
          $display("FAIL burst_rd it%0d k%0d: got %02h, required %02h", it, k, d, bytes[k]);
        end
        wait_idle();
      end
      exp_addr = ADDR_W'((int'(base) + 5) % DEPTH);
      vectors++;
      if (dut_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL burst_rd_addr it%0d: got %h, required %h", it, dut_addr, exp_addr);
      end
      host_read(8'h16, d);
      vectors++;
      if (d !== 8'h02) begin
        miscompares++;
        $display("FAIL burst_status it%0d: got %02h, required 02", it, d);
      end
    end
  endtask

  task automatic test_reset_midcycle();
    logic [7:0] d;
    host_write(8'h11, 8'h00);
    host_write(8'h15, 8'h04);
    host_write(8'h12, 8'h40);
    host_write(8'h13, 8'h00);
    host_write(8'h10, 8'h77);
    @(negedge clk);
    vectors++;
    if (dut_we_n !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_pulse: we_n=%b, required 0", dut_we_n);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dut_we_n, dut_ce_n, dut_oe_n, dut_dq_oe, busy} !== 5'b11100) begin
      miscompares++;
      $display("FAIL midreset_strobes: got %b, required 11100",
               {dut_we_n, dut_ce_n, dut_oe_n, dut_dq_oe, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (dut_addr !== '0 || dut_dq_out !== '0 || reg_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_regs: addr=%h dq=%h rdata=%h, required 0", dut_addr, dut_dq_out, reg_rdata);
    end
    host_read(8'h16, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_status: got %02h, required 00", d);
    end
    host_read(8'h10, d);
    vectors++;
    if (d !== 8'h00 || dut_ce_n !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_rbuf: rbuf=%02h ce_n=%b, required 00/1", d, dut_ce_n);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = 8'h00;
    test_reset();
    test_write_cycle();
    test_prefetch_wrap();
    test_read_wait0();
    test_busy_reject();
    test_burst_random();
    test_reset_midcycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_bulk_engine.md
Name: sram_bulk_engine

Overview:
- Clocked, parametrised successor of the fixed HM62256 bottomhalf; drives any asynchronous parallel SRAM (ADDR_W x DATA_W) from the ZIF adapter.
- The host writes and reads byte-wide registers. An internal FSM generates /CE, /OE and /WE cycles with programmable pulse width, auto-incrementing address and read prefetch, so bulk transfers need one host access per byte.
- Pin mapping to zif[] stays in the per-chip top level; this block exposes logical DUT signals.

Parameters:
- ADDR_W, 15, DUT address width (1..24).
- DATA_W, 8, DUT data width (1..8).
- WAIT_W, 4, width of the pulse-width register.
- RUNTIME_ID, 16'h000B, value returned at registers FD/FE.
- RUNTIME_REV, 8'h01, value returned at register FF.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reg_addr  in  8  host register address, latched by the host-side glue from ALE
- reg_wdata  in  8  host write data
- reg_wr  in  1  one-cycle write strobe
- reg_rd  in  1  one-cycle read strobe
- reg_rdata  out  8  registered read data
- dut_addr  out  ADDR_W  DUT address
- dut_dq_out  out  DATA_W  data driven to the DUT
- dut_dq_oe  out  1  drive enable for dut_dq_out
- dut_dq_in  in  DATA_W  data sampled from the DUT
- dut_ce_n / dut_oe_n / dut_we_n  out  1 each  DUT strobes, active low
- busy  out  1  a cycle is in progress

Behaviour:
- Reset values (asynchronous, all registers): dut_ce_n=dut_oe_n=dut_we_n=1, dut_dq_oe=0, dut_addr=0, dut_dq_out=0, reg_rdata=0, wait=0, ctrl=0, rbuf=0, rvalid=0, ovr=0, busy=0, FSM=IDLE.
- Reset asserted mid-cycle: strobes deassert immediately. No partial write completes.
- Register map (reg_addr):
  - 10 W: load dut_dq_out and start a WRITE cycle.
  - 10 R: return rbuf and clear rvalid. If ctrl[2] (prefetch) is set, start a READ cycle at the current address.
  - 11 W: ctrl[1] = auto-increment, ctrl[2] = prefetch. Writing bit0=1 starts a READ cycle; bit0 is not stored.
  - 12/13/14 W: address bytes 0/1/2. Bits at or above ADDR_W are discarded.
  - 15 W: wait = reg_wdata[WAIT_W-1:0].
  - 16 R: status {5'b0, ovr, rvalid, busy}. Reading clears ovr.
  - FD/FE/FF R: RUNTIME_ID[7:0], RUNTIME_ID[15:8], RUNTIME_REV.
  - Any other read returns 0; any other write is ignored.
- reg_rdata is updated on the clock edge at which reg_rd is sampled high and is valid from the next cycle until the next reg_rd.
- FSM states and outputs:
  - IDLE: all strobes high.
  - SETUP: 1 cycle. CE low. For a write, dq_oe=1.
  - PULSE: wait+1 cycles. OE low (read) or WE low (write). Write keeps dq_oe=1.
  - HOLD: 1 cycle. OE/WE high, CE low. Write keeps dq_oe=1. Read captures dut_dq_in into rbuf on entry to HOLD and sets rvalid.
  - IDLE follows HOLD.
- busy is high from the cycle after the starting strobe through HOLD. Total cycle length is wait+3 clocks.
- Auto-increment: on leaving HOLD with ctrl[1]=1, dut_addr+1 modulo 2^ADDR_W. The top address wraps to 0; there is no flag.
- Host access while busy:
  - Start commands and writes to 10/12/13/14/15 are ignored and set ovr (sticky).
  - Reads of 10 while busy return the old rbuf, set ovr, and do not prefetch.
  - Status and ID reads are always allowed.
- Simultaneous reg_wr and reg_rd: the write is processed, then the read returns pre-write state.
- rvalid is set by a completed read and cleared by a read of 10 in the same cycle: set wins.

Decomposition:
- Shared package/include sram_engine_pkg:
  - register address constants (10..16, FD..FF)
  - FSM state encoding (IDLE/SETUP/PULSE/HOLD)
  - status bit positions
  - cycle-type enum (READ/WRITE)
- One sub-module, sram_cycle_fsm, contains the timing FSM, wait counter, strobe/dq_oe generation and capture pulse.
- The parent holds the register file, address counter and host decode.

Test Plan:
- Reset, then read FD/FE/FF, then read 16 -> 0x0B, 0x00, 0x01, then 0x00. All strobes high, dq_oe=0.
- wait=2, addr=0x1234, write 10=0xA5 -> CE low 5 clocks; WE low exactly 3 clocks (cycles 2-4); dq_oe high for all 5 clocks; dut_dq_out=0xA5. No address change (ctrl[1]=0).
- ctrl=0x06, addr=0x7FFF (ADDR_W=15), write 11=0x07, with the DUT model returning 0x3C then 0x5A -> first read 10 returns 0x3C and starts a prefetch at 0x0000 (wrapped). Once busy drops, read 10 returns 0x5A.
- wait=0 READ -> busy for exactly 3 clocks. OE low 1 clock. rvalid=1 afterwards. Status reads 0x02.
- While busy, write 12=0xFF and write 10=0x11 -> address and data unchanged, no second cycle, status bit2=1. A second status read returns bit2=0.
- Assert rst_n during PULSE of a write -> dut_we_n=1, dut_ce_n=1 and dut_dq_oe=0 in the same delta. busy=0. Registers hold reset values after release.
